audio_bit_clock_gen: RTL and testbench
======================================

# audio_bit_clock_gen

Generates the serial-audio bit clock (BCLK), the left/right frame clock (LRCLK) and one-cycle sample strobes for the codec serializer. It runs in the 18.432 MHz audio clock domain directly downstream of the audio PLL. It qualifies the PLL `locked` indication before it starts any clock. On loss of lock it stops cleanly and restarts from a known phase.

## Interface
- `BCLK_DIV`, 6: clk cycles per BCLK period; even, ≥2 (18.432 MHz / 6 = 3.072 MHz).
- `BCLKS_PER_FRAME`, 64: BCLK periods per LRCLK frame; even, ≥2 (3.072 MHz / 64 = 48 kHz).
- `LOCK_WAIT`, 1024: clk cycles lock must stay high before output starts; ≥1.

Ports:
- `clk` in 1: audio clock from the PLL `outclk_0`.
- `reset_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock, asynchronous to `clk`.
- `bclk` out 1: registered bit clock.
- `lrclk` out 1: registered frame clock; 1 = left channel, 0 = right channel.
- `bclk_rise_stb` out 1: high in the first cycle `bclk` is 1.
- `bclk_fall_stb` out 1: high in the first cycle `bclk` is 0.
- `frame_stb` out 1: high in the cycle a new frame (left slot, bit 0) begins.
- `ready` out 1: high while clocks are running.

## Operation
- `pll_locked` passes through a 2-flop synchronizer, giving `lock_s`.
- The state machine has three states:
  - WAIT_LOCK, the reset state. Goes to SETTLE when `lock_s` = 1.
  - SETTLE. A settle counter counts from 0. If `lock_s` = 0, go to WAIT_LOCK. When the counter reaches LOCK_WAIT−1, go to RUN.
  - RUN. If `lock_s` = 0, go to WAIT_LOCK.
- In RUN:
  - `div_cnt` runs 0..BCLK_DIV−1 and wraps.
  - `bit_cnt` advances when `div_cnt` wraps, runs 0..BCLKS_PER_FRAME−1, and wraps.
- Output values in RUN:
  - `bclk` = 0 when `div_cnt` < BCLK_DIV/2, otherwise 1.
  - `lrclk` = 1 when `bit_cnt` < BCLKS_PER_FRAME/2, otherwise 0.
  - Both outputs are registered and aligned to the cycle that holds those counter values.
- Strobes:
  - `bclk_fall_stb` = 1 when `div_cnt` = 0.
  - `bclk_rise_stb` = 1 when `div_cnt` = BCLK_DIV/2.
  - `frame_stb` = 1 when `div_cnt` = 0 and `bit_cnt` = 0.
- Outside RUN:
  - `bclk` = 0, `lrclk` = 1, all strobes 0, `ready` = 0.
  - Counters are held at 0.
- Lock loss in RUN:
  - Outputs go to the idle values in the cycle after `lock_s` falls, even mid-bit or mid-frame.
  - The next RUN entry starts again at `div_cnt` = 0, `bit_cnt` = 0.
- Lock loss in SETTLE clears the settle counter, so a full LOCK_WAIT is required again.

## Timing
- Reset values: `bclk` 0, `lrclk` 1, `bclk_rise_stb` 0, `bclk_fall_stb` 0, `frame_stb` 0, `ready` 0. Reset is asynchronous and takes effect immediately, in any state.
- Lock acquisition latency: `pll_locked` rising to `lock_s` is 2 cycles. The FSM is in SETTLE on the next edge.
- RUN entry: after LOCK_WAIT cycles in SETTLE, RUN is entered. In the first RUN cycle `ready` = 1, `frame_stb` = 1, `bclk_fall_stb` = 1, `bclk` = 0 and `lrclk` = 1.
- Lock loss latency: `pll_locked` falling to `ready` = 0 is 3 cycles (2 synchronizer + 1).
- Periods:
  - `bclk` period is exactly BCLK_DIV cycles, 50% duty.
  - `lrclk` period is BCLK_DIV × BCLKS_PER_FRAME cycles (384 at defaults), 50% duty.
- `lrclk` changes only in cycles where `bclk_fall_stb` = 1.
- Every strobe is exactly one cycle wide. `frame_stb` implies `bclk_fall_stb`.

## Configuration
- Macro: `AUDIO_BIT_CLOCK_GEN_LOSS_CNT_EN`.
- Defined:
  - Adds output `lock_loss_cnt` [7:0], reset 0.
  - It increments by 1 on each RUN→WAIT_LOCK transition and saturates at 255.
  - Counting stops at 255; only reset returns it to 0.
  - Transitions from SETTLE to WAIT_LOCK are not counted.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then `pll_locked` = 1 held, defaults: `ready` rises exactly 2 + 1 + 1024 cycles after the lock edge. The first RUN cycle shows `frame_stb` = 1, `bclk` = 0, `lrclk` = 1.
- Steady RUN, defaults, 1000 frames:
  - `bclk` period 6 (3 low, 3 high); `lrclk` period 384, high for 192 cycles.
  - Exactly 1 `frame_stb` per 384 cycles and 64 `bclk_rise_stb` per frame.
  - No `lrclk` change outside `bclk_fall_stb` cycles.
- Lock glitch in SETTLE: drop `pll_locked` for 5 cycles at settle count 500. `ready` stays 0, and RUN is entered LOCK_WAIT cycles after the re-lock is synchronized.
- Lock loss mid-frame, at `bit_cnt` = 40, `div_cnt` = 4:
  - 3 cycles later `bclk` = 0, `lrclk` = 1, `ready` = 0.
  - After re-lock and settle, the first RUN cycle has `frame_stb` = 1.
- `reset_n` asserted asynchronously mid-RUN: all outputs reach their reset values before the next `clk` edge and stay there until lock is re-qualified.
- With `AUDIO_BIT_CLOCK_GEN_LOSS_CNT_EN`:
  - 3 RUN lock losses give `lock_loss_cnt` = 3.
  - 2 losses in SETTLE leave the count unchanged.
  - 300 RUN losses leave it at 255.

Source files
------------

// File: rtl/audio_bit_clock_gen.sv
// audio_bit_clock_gen: serial-audio BCLK / LRCLK generator with PLL lock qualification.
//   clk            in  audio clock (PLL outclk_0)
//   reset_n        in  asynchronous active-low reset
//   pll_locked     in  PLL lock, asynchronous to clk (synchronized internally)
//   bclk           out registered bit clock, BCLK_DIV clk cycles per period
//   lrclk          out registered frame clock, 1 = left, 0 = right
//   bclk_rise_stb  out first cycle bclk is 1
//   bclk_fall_stb  out first cycle bclk is 0
//   frame_stb      out first cycle of a frame (left slot, bit 0)
//   ready          out clocks running
//   lock_loss_cnt  out [7:0] saturating count of RUN lock losses
//                      (only with AUDIO_BIT_CLOCK_GEN_LOSS_CNT_EN defined)
module audio_bit_clock_gen #(
  parameter int unsigned BCLK_DIV        = 6,
  parameter int unsigned BCLKS_PER_FRAME = 64,
  parameter int unsigned LOCK_WAIT       = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       bclk,
  output logic       lrclk,
  output logic       bclk_rise_stb,
  output logic       bclk_fall_stb,
  output logic       frame_stb,
  output logic       ready
`ifdef AUDIO_BIT_CLOCK_GEN_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  localparam int unsigned DIV_W    = $clog2(BCLK_DIV);
  localparam int unsigned BIT_W    = $clog2(BCLKS_PER_FRAME);
  localparam int unsigned SET_W    = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam int unsigned DIV_HALF = BCLK_DIV / 2;
  localparam int unsigned BIT_HALF = BCLKS_PER_FRAME / 2;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic             sync_q1;
  logic             lock_s;
  state_t           state, state_nxt;
  logic [SET_W-1:0] settle_cnt, settle_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_nxt;
  logic             bclk_nxt, lrclk_nxt, rise_nxt, fall_nxt, frame_nxt, ready_nxt;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync_q1 <= pll_locked;
      lock_s  <= sync_q1;
    end
  end

  // Next state, next counters, and outputs derived from the next counter values
  // so that each registered output lands in the same cycle as its counters.
  always_comb begin
    state_nxt  = state;
    settle_nxt = '0;
    div_nxt    = '0;
    bit_nxt    = '0;
    bclk_nxt   = 1'b0;
    lrclk_nxt  = 1'b1;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    frame_nxt  = 1'b0;
    ready_nxt  = 1'b0;

    case (state)
      WAIT_LOCK: begin
        if (lock_s) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (settle_cnt == SET_W'(LOCK_WAIT - 1)) begin
          state_nxt = RUN;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (div_cnt == DIV_W'(BCLK_DIV - 1)) begin
          div_nxt = '0;
          bit_nxt = (bit_cnt == BIT_W'(BCLKS_PER_FRAME - 1)) ? '0 : bit_cnt + 1'b1;
        end else begin
          div_nxt = div_cnt + 1'b1;
          bit_nxt = bit_cnt;
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase

    // Counters leave SETTLE at zero, so RUN entry always starts a fresh frame.
    if (state_nxt == RUN) begin
      ready_nxt = 1'b1;
      bclk_nxt  = (div_nxt >= DIV_W'(DIV_HALF));
      lrclk_nxt = (bit_nxt < BIT_W'(BIT_HALF));
      fall_nxt  = (div_nxt == '0);
      rise_nxt  = (div_nxt == DIV_W'(DIV_HALF));
      frame_nxt = (div_nxt == '0) && (bit_nxt == '0);
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= WAIT_LOCK;
      settle_cnt    <= '0;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      bclk          <= 1'b0;
      lrclk         <= 1'b1;
      bclk_rise_stb <= 1'b0;
      bclk_fall_stb <= 1'b0;
      frame_stb     <= 1'b0;
      ready         <= 1'b0;
    end else begin
      state         <= state_nxt;
      settle_cnt    <= settle_nxt;
      div_cnt       <= div_nxt;
      bit_cnt       <= bit_nxt;
      bclk          <= bclk_nxt;
      lrclk         <= lrclk_nxt;
      bclk_rise_stb <= rise_nxt;
      bclk_fall_stb <= fall_nxt;
      frame_stb     <= frame_nxt;
      ready         <= ready_nxt;
    end
  end

`ifdef AUDIO_BIT_CLOCK_GEN_LOSS_CNT_EN
  // Saturating count of lock losses while running; SETTLE aborts are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_cnt <= 8'd0;
    end else if ((state == RUN) && (state_nxt == WAIT_LOCK) && (lock_loss_cnt != 8'hFF)) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_audio_bit_clock_gen.sv
// tb_audio_bit_clock_gen: self-checking bench for audio_bit_clock_gen against a
// run-length reference model (outputs derived from how long lock has been held).
module tb_audio_bit_clock_gen;

  localparam int unsigned DIV = 6;
  localparam int unsigned BPF = 64;
`ifdef AUDIO_BIT_CLOCK_GEN_LOSS_CNT_EN
  localparam int unsigned LW  = 16;
`else
  localparam int unsigned LW  = 1024;
`endif
  localparam int unsigned FRAME_CYC = DIV * BPF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pll_locked = 1'b0;
  logic bclk, lrclk, bclk_rise_stb, bclk_fall_stb, frame_stb, ready;
`ifdef AUDIO_BIT_CLOCK_GEN_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  audio_bit_clock_gen #(
    .BCLK_DIV        (DIV),
    .BCLKS_PER_FRAME (BPF),
    .LOCK_WAIT       (LW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .bclk_rise_stb (bclk_rise_stb),
    .bclk_fall_stb (bclk_fall_stb),
    .frame_stb     (frame_stb),
    .ready         (ready)
`ifdef AUDIO_BIT_CLOCK_GEN_LOSS_CNT_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: lock seen by the core is pll_locked two edges late; clocks
  // run once it has been seen high for LW+1 consecutive edges, and all outputs
  // are then pure functions of the cycle index t since RUN entry.
  bit h0, h1;
  int run_len = 0;
  int loss_m = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h0 = 1'b0;
      h1 = 1'b0;
      run_len = 0;
      loss_m = 0;
    end else begin
      bit ls;
      ls = h1;
      h1 = h0;
      h0 = pll_locked;
      if (ls) begin
        run_len++;
      end else begin
        if (run_len >= int'(LW + 1) && loss_m < 255) loss_m++;
        run_len = 0;
      end
    end
  end

  function automatic int model_t();
    return run_len - int'(LW + 1);
  endfunction

  // {ready, bclk, lrclk, rise, fall, frame}
  function automatic logic [5:0] exp_vec();
    int t, d, b;
    if (run_len < int'(LW + 1)) return 6'b001000;
    t = model_t();
    d = t % int'(DIV);
    b = (t / int'(DIV)) % int'(BPF);
    return {1'b1, d >= int'(DIV / 2), b < int'(BPF / 2), d == int'(DIV / 2), d == 0,
            (d == 0) && (b == 0)};
  endfunction

  wire [5:0] obs_vec = {ready, bclk, lrclk, bclk_rise_stb, bclk_fall_stb, frame_stb};

  task automatic test_reset();
    reset_n = 1'b0;
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_vec !== 6'b001000) begin
      errors++;
      $display("FAIL reset_values obs=%b exp=%b", obs_vec, 6'b001000);
    end
`ifdef AUDIO_BIT_CLOCK_GEN_LOSS_CNT_EN
    checks++;
    if (lock_loss_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_loss_cnt obs=%0d exp=0", lock_loss_cnt);
    end
`endif
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_acquire();
    int n = 0;
    pll_locked = 1'b1;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL acquire_vec cyc=%0d obs=%b exp=%b", n, obs_vec, exp_vec());
      end
      if (ready) break;
    end
    checks++;
    if (n != int'(LW + 3)) begin
      errors++;
      $display("FAIL acquire_latency obs=%0d exp=%0d", n, LW + 3);
    end
    checks++;
    if ({frame_stb, bclk_fall_stb, bclk, lrclk} !== 4'b1101) begin
      errors++;
      $display("FAIL first_run_cycle obs=%b exp=1101", {frame_stb, bclk_fall_stb, bclk, lrclk});
    end
  endtask

  task automatic test_steady(input int frames);
    int rises = 0, falls = 0, frms = 0, lr_bad = 0, per_bad = 0, last_rise = -1, cyc = 0;
    logic prev_lr = lrclk;
    repeat (frames * int'(FRAME_CYC)) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL steady_vec t=%0d obs=%b exp=%b", model_t(), obs_vec, exp_vec());
      end
      if (bclk_rise_stb) begin
        if (last_rise >= 0 && cyc - last_rise != int'(DIV)) per_bad++;
        last_rise = cyc;
        rises++;
      end
      if (bclk_fall_stb) falls++;
      if (frame_stb) frms++;
      if (lrclk !== prev_lr && !bclk_fall_stb) lr_bad++;
      prev_lr = lrclk;
    end
    checks++;
    if (rises != frames * int'(BPF) || falls != frames * int'(BPF)) begin
      errors++;
      $display("FAIL steady_bclk_count rises=%0d falls=%0d exp=%0d", rises, falls, frames * BPF);
    end
    checks++;
    if (frms != frames) begin
      errors++;
      $display("FAIL steady_frame_count obs=%0d exp=%0d", frms, frames);
    end
    checks++;
    if (lr_bad != 0 || per_bad != 0) begin
      errors++;
      $display("FAIL steady_lr_align lr_bad=%0d per_bad=%0d exp=0", lr_bad, per_bad);
    end
  endtask

  task automatic test_settle_glitch();
    int n = 0;
    pll_locked = 1'b0;
    repeat (6 + $urandom_range(3)) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_drop_vec obs=%b exp=%b", obs_vec, exp_vec());
      end
    end
    pll_locked = 1'b1;
    repeat (503) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_settle_vec obs=%b exp=%b", obs_vec, exp_vec());
      end
    end
    pll_locked = 1'b0;
    repeat (5) @(negedge clk);
    pll_locked = 1'b1;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_relock_vec cyc=%0d obs=%b exp=%b", n, obs_vec, exp_vec());
      end
      if (ready) break;
    end
    checks++;
    if (n != int'(LW + 3)) begin
      errors++;
      $display("FAIL glitch_relock_latency obs=%0d exp=%0d", n, LW + 3);
    end
  endtask

  task automatic test_midframe_loss();
    int n = 0;
    int target = 40 * int'(DIV) + 4;
    repeat ($urandom_range(FRAME_CYC)) @(negedge clk);
    while (n < int'(2 * FRAME_CYC) && !(ready && (model_t() % int'(FRAME_CYC)) == target)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({ready, bclk, lrclk} !== 3'b110) begin
      errors++;
      $display("FAIL midframe_pos obs=%b exp=110 waited=%0d", {ready, bclk, lrclk}, n);
    end
    pll_locked = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL midframe_loss_vec i=%0d obs=%b exp=%b", i, obs_vec, exp_vec());
      end
      checks++;
      if (ready !== (i < 3)) begin
        errors++;
        $display("FAIL midframe_loss_latency i=%0d ready=%b exp=%b", i, ready, i < 3);
      end
    end
    checks++;
    if ({bclk, lrclk} !== 2'b01) begin
      errors++;
      $display("FAIL midframe_idle obs=%b exp=01", {bclk, lrclk});
    end
    repeat ($urandom_range(4, 10)) @(negedge clk);
    pll_locked = 1'b1;
    n = 0;
    while (n < 3000 && !ready) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({ready, frame_stb, n} !== {2'b11, 32'(LW + 3)}) begin
      errors++;
      $display("FAIL midframe_restart ready=%b frame=%b cyc=%0d exp=1,1,%0d", ready, frame_stb, n, LW + 3);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    repeat ($urandom_range(FRAME_CYC)) @(negedge clk);
    while (n < int'(2 * FRAME_CYC) && !(bclk && !lrclk)) begin
      @(negedge clk);
      n++;
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (obs_vec !== 6'b001000) begin
      errors++;
      $display("FAIL async_reset_immediate obs=%b exp=001000", obs_vec);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL async_reset_relock_vec cyc=%0d obs=%b exp=%b", n, obs_vec, exp_vec());
      end
      if (ready) break;
    end
    checks++;
    if (n != int'(LW + 3)) begin
      errors++;
      $display("FAIL async_reset_relock_latency obs=%0d exp=%0d", n, LW + 3);
    end
  endtask

`ifdef AUDIO_BIT_CLOCK_GEN_LOSS_CNT_EN
  task automatic run_and_lose(input bit reach_run);
    int n = 0;
    pll_locked = 1'b1;
    if (reach_run) begin
      while (n < 200 && !ready) begin
        @(negedge clk);
        n++;
      end
      repeat ($urandom_range(3)) @(negedge clk);
    end else begin
      repeat (LW / 2) @(negedge clk);
    end
    pll_locked = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loss_cnt();
    reset_n = 1'b0;
    pll_locked = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) run_and_lose(1'b1);
    checks++;
    if (lock_loss_cnt !== 8'd3 || loss_m != 3) begin
      errors++;
      $display("FAIL loss_cnt_three obs=%0d model=%0d exp=3", lock_loss_cnt, loss_m);
    end
    repeat (2) run_and_lose(1'b0);
    checks++;
    if (lock_loss_cnt !== 8'd3) begin
      errors++;
      $display("FAIL loss_cnt_settle obs=%0d exp=3", lock_loss_cnt);
    end
    repeat (297) run_and_lose(1'b1);
    checks++;
    if (lock_loss_cnt !== 8'd255 || loss_m != 255) begin
      errors++;
      $display("FAIL loss_cnt_saturate obs=%0d model=%0d exp=255", lock_loss_cnt, loss_m);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_acquire();
    test_steady(20);
    test_settle_glitch();
    test_midframe_loss();
    test_steady(2);
    test_async_reset();
`ifdef AUDIO_BIT_CLOCK_GEN_LOSS_CNT_EN
    test_loss_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
